wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural integer register file; the destination end of the writeback path.
- Accepts the selected writeback word (PC+4, ALU result, U-immediate or load data) plus a destination index and write enable. Commits the word on the clock edge.
- Serves two combinational source-operand read ports to decode/execute of the single-cycle core.
- Enforces x0 = 0. Optional same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, data width of each register and of all data ports
- NREGS, 32, number of architectural registers; index width AW = clog2(NREGS) = 5
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns wbdata; 0 = returns the stored (old) value

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- regwrite  input  1  write enable from control
- rd  input  AW  destination register index
- wbdata  input  XLEN  writeback word from the writeback select stage
- rs1  input  AW  source index, port 1
- rs2  input  AW  source index, port 2
- rdata1  output  XLEN  operand read for rs1
- rdata2  output  XLEN  operand read for rs2
- wr_count  output  32  count of committed non-x0 writes since reset (debug/perf)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: on a rising edge with rst=1, all registers x0..x(NREGS-1) become 0 and wr_count becomes 0.
  - rst has priority over regwrite; a write presented in the reset cycle is discarded.
  - After reset, both read ports return 0 for every index.
- Write:
  - On a rising edge with rst=0, regwrite=1 and rd!=0, register[rd] <= wbdata and wr_count <= wr_count+1.
  - Latency is 1 edge: the value is visible on the stored path in the cycle after the edge.
- x0:
  - A write with rd=0 is ignored; storage of x0 always holds 0.
  - wr_count does not increment on an rd=0 write.
  - Reads of index 0 return 0 regardless of BYPASS, regwrite or wbdata.
- regwrite=0: no state change; wr_count holds.
- Read ports:
  - Purely combinational, with no clock latency. rdataN = register[rsN], subject to the overrides below.
  - Both ports are independent; rs1=rs2 is legal and both return the same value.
- Bypass (BYPASS=1):
  - If regwrite=1, rst=0, rd!=0 and rsN==rd, then rdataN = wbdata in the same cycle.
  - This applies to both ports simultaneously.
  - With BYPASS=0, rdataN shows the pre-edge stored value until the edge.
- Bypass during reset: when rst=1, the bypass is suppressed and reads show stored contents.
- Write-after-write: back-to-back writes to the same rd on consecutive edges leave the last value; each write counts.
- wr_count wraps from 0xFFFFFFFF to 0.
- Indices >= NREGS (only possible when NREGS is not a power of 2):
  - Writes are ignored and not counted.
  - Reads return 0.
- X-safety: no output may be X after the first reset edge, provided inputs are known.

Test Plan:
- Reset: hold rst=1 for 2 edges with regwrite=1, rd=5, wbdata=0xDEADBEEF -> after rst=0, rdata1 (rs1=5) = 0, wr_count = 0.
- Basic writes and reads:
  - Write rd=1 with 4, rd=2 with 16, rd=3 with 32, rd=4 with 48 on consecutive edges.
  - Then rs1=1, rs2=4 -> rdata1=4, rdata2=48.
  - Then rs1=2, rs2=3 -> rdata1=16, rdata2=32.
  - wr_count = 4.
- x0 protection: regwrite=1, rd=0, wbdata=0x12345678, one edge -> rs1=0 gives rdata1=0, and wr_count is unchanged.
- Bypass, with BYPASS=1 and register 7 holding 0x11:
  - Present regwrite=1, rd=7, wbdata=0x22, rs1=7, rs2=7 before the edge -> rdata1=rdata2=0x22 combinationally.
  - After the edge, with regwrite=0 -> both still 0x22.
  - Rerun with BYPASS=0 -> 0x11 before the edge, 0x22 after.
- Write disabled and WAW:
  - regwrite=0, rd=9, wbdata=0xFF, one edge -> rdata(9)=0.
  - Then write 0xA, then 0xB to rd=9 on consecutive edges -> rdata(9)=0xB, wr_count incremented by 2.
- Mid-run reset: after populating x1..x31 with their own index, assert rst for one edge while regwrite=1, rd=31, wbdata=0x55 -> all 31 registers read 0, wr_count=0, rdata for rs1=31 shows 0 during the rst=1 cycle.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the writeback stage / decode and the register file.
// regwrite qualifies rd/wbdata for exactly the current cycle; there is no
// backpressure, so every cycle with regwrite=1 (rst=0, rd!=0) is a committed write.
interface wb_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            regwrite;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wbdata;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [31:0]     wr_count;

    modport master (
        output regwrite, rd, wbdata, rs1, rs2,
        input  rdata1, rdata2, wr_count
    );

    modport slave (
        input  regwrite, rd, wbdata, rs1, rs2,
        output rdata1, rdata2, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Architectural integer register file: one clocked write port, two
// combinational read ports, hardwired x0 and optional write-to-read bypass.
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int AWP1 = AW + 1;
    localparam logic [AW:0] LP_NREGS = AWP1'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_wr_count;

    logic            w_wr_en;
    logic            w_rs1_ok;
    logic            w_rs2_ok;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;

    // A write commits only outside reset, to a real, non-zero register.
    assign w_wr_en  = bus.regwrite && !rst && (bus.rd != '0) &&
                      ({1'b0, bus.rd} < LP_NREGS);
    assign w_rs1_ok = (bus.rs1 != '0) && ({1'b0, bus.rs1} < LP_NREGS);
    assign w_rs2_ok = (bus.rs2 != '0) && ({1'b0, bus.rs2} < LP_NREGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.rd] <= bus.wbdata;
            r_wr_count     <= r_wr_count + 32'd1;
        end
    end

    // x0 and out-of-range indices read as 0; bypass is folded into w_wr_en,
    // so it is already suppressed during reset.
    always_comb begin
        w_rdata1 = '0;
        if (w_rs1_ok) begin
            if (BYPASS && w_wr_en && (bus.rs1 == bus.rd)) begin
                w_rdata1 = bus.wbdata;
            end else begin
                w_rdata1 = r_regs[bus.rs1];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        if (w_rs2_ok) begin
            if (BYPASS && w_wr_en && (bus.rs2 == bus.rd)) begin
                w_rdata2 = bus.wbdata;
            end else begin
                w_rdata2 = r_regs[bus.rs2];
            end
        end
    end

    assign bus.rdata1   = w_rdata1;
    assign bus.rdata2   = w_rdata2;
    assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a BYPASS=1 instance (ifa) and a BYPASS=0
// instance (ifb) receive identical stimulus.
module tb_wb_regfile;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if #(.XLEN(32), .AW(5)) ifa ();
    wb_regfile_if #(.XLEN(32), .AW(5)) ifb ();

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        ifa.regwrite = we; ifa.rd = rd; ifa.wbdata = wd; ifa.rs1 = rs1; ifa.rs2 = rs2;
        ifb.regwrite = we; ifb.rd = rd; ifb.wbdata = wd; ifb.rs1 = rs1; ifb.rs2 = rs2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        tick();
        checks++;
        if (ifa.rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_rst_rdata1 got=%h exp=%h", ifa.rdata1, 32'd0);
        end
        rst = 1'b0;
        drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        checks++;
        if (ifa.rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata1 got=%h exp=%h", ifa.rdata1, 32'd0);
        end
        checks++;
        if (ifa.wr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_wr_count got=%0d exp=0", ifa.wr_count);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            checks++;
            if (ifa.rdata1 !== 32'd0 || ifa.rdata2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_all_idx%0d got=%h/%h exp=0", i, ifa.rdata1, ifa.rdata2);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd1, 32'd4,  5'd0, 5'd0); tick();
        drive(1'b1, 5'd2, 32'd16, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd3, 32'd32, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd4, 32'd48, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0,  5'd1, 5'd4);
        checks++;
        if (ifa.rdata1 !== 32'd4 || ifa.rdata2 !== 32'd48) begin
            errors++;
            $display("FAIL basic_r1_r4 got=%0d/%0d exp=4/48", ifa.rdata1, ifa.rdata2);
        end
        drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
        checks++;
        if (ifa.rdata1 !== 32'd16 || ifa.rdata2 !== 32'd32) begin
            errors++;
            $display("FAIL basic_r2_r3 got=%0d/%0d exp=16/32", ifa.rdata1, ifa.rdata2);
        end
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        checks++;
        if (ifa.rdata1 !== 32'd32 || ifa.rdata2 !== 32'd32) begin
            errors++;
            $display("FAIL basic_same_idx got=%0d/%0d exp=32/32", ifa.rdata1, ifa.rdata2);
        end
        checks++;
        if (ifa.wr_count !== 32'd4) begin
            errors++;
            $display("FAIL basic_wr_count got=%0d exp=4", ifa.wr_count);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        checks++;
        if (ifa.rdata1 !== 32'd0 || ifa.rdata2 !== 32'd0) begin
            errors++;
            $display("FAIL x0_no_bypass got=%h/%h exp=0", ifa.rdata1, ifa.rdata2);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++;
        if (ifa.rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL x0_stored got=%h exp=0", ifa.rdata1);
        end
        checks++;
        if (ifa.wr_count !== 32'd4) begin
            errors++;
            $display("FAIL x0_wr_count got=%0d exp=4", ifa.wr_count);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h11, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        checks++;
        if (ifa.rdata1 !== 32'h22 || ifa.rdata2 !== 32'h22) begin
            errors++;
            $display("FAIL bypass1_pre_edge got=%h/%h exp=22/22", ifa.rdata1, ifa.rdata2);
        end
        checks++;
        if (ifb.rdata1 !== 32'h11 || ifb.rdata2 !== 32'h11) begin
            errors++;
            $display("FAIL bypass0_pre_edge got=%h/%h exp=11/11", ifb.rdata1, ifb.rdata2);
        end
        tick();
        drive(1'b0, 5'd7, 32'h22, 5'd7, 5'd7);
        checks++;
        if (ifa.rdata1 !== 32'h22 || ifa.rdata2 !== 32'h22) begin
            errors++;
            $display("FAIL bypass1_post_edge got=%h/%h exp=22/22", ifa.rdata1, ifa.rdata2);
        end
        checks++;
        if (ifb.rdata1 !== 32'h22 || ifb.rdata2 !== 32'h22) begin
            errors++;
            $display("FAIL bypass0_post_edge got=%h/%h exp=22/22", ifb.rdata1, ifb.rdata2);
        end
        checks++;
        if (ifa.wr_count !== 32'd6 || ifb.wr_count !== 32'd6) begin
            errors++;
            $display("FAIL bypass_wr_count got=%0d/%0d exp=6", ifa.wr_count, ifb.wr_count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 5'd9, 32'hFF, 5'd9, 5'd9); tick();
        checks++;
        if (ifa.rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL wr_disabled got=%h exp=0", ifa.rdata1);
        end
        checks++;
        if (ifa.wr_count !== 32'd6) begin
            errors++;
            $display("FAIL wr_disabled_count got=%0d exp=6", ifa.wr_count);
        end
        drive(1'b1, 5'd9, 32'hA, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 32'hB, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        checks++;
        if (ifa.rdata1 !== 32'hB || ifb.rdata2 !== 32'hB) begin
            errors++;
            $display("FAIL waw_value got=%h/%h exp=b/b", ifa.rdata1, ifb.rdata2);
        end
        checks++;
        if (ifa.wr_count !== 32'd8) begin
            errors++;
            $display("FAIL waw_wr_count got=%0d exp=8", ifa.wr_count);
        end
    endtask

    task automatic test_midrun_reset();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd31);
        checks++;
        if (ifa.rdata1 !== 32'd17 || ifa.rdata2 !== 32'd31) begin
            errors++;
            $display("FAIL populate got=%0d/%0d exp=17/31", ifa.rdata1, ifa.rdata2);
        end
        checks++;
        if (ifa.wr_count !== 32'd39) begin
            errors++;
            $display("FAIL populate_wr_count got=%0d exp=39", ifa.wr_count);
        end
        rst = 1'b1;
        drive(1'b1, 5'd31, 32'h55, 5'd31, 5'd31);
        // Bypass is suppressed in reset: still the stored 31 before the edge.
        checks++;
        if (ifa.rdata1 !== 32'd31) begin
            errors++;
            $display("FAIL rst_no_bypass got=%h exp=%h", ifa.rdata1, 32'd31);
        end
        tick();
        checks++;
        if (ifa.rdata1 !== 32'd0 || ifa.rdata2 !== 32'd0) begin
            errors++;
            $display("FAIL rst_cycle_rdata got=%h/%h exp=0", ifa.rdata1, ifa.rdata2);
        end
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++;
        if (ifa.wr_count !== 32'd0) begin
            errors++;
            $display("FAIL midrst_wr_count got=%0d exp=0", ifa.wr_count);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i));
            checks++;
            if (ifa.rdata1 !== 32'd0 || ifb.rdata2 !== 32'd0) begin
                errors++;
                $display("FAIL midrst_idx%0d got=%h/%h exp=0", i, ifa.rdata1, ifb.rdata2);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
